// File: rtl/mem_bus_decoder.sv
// Address decoder bridging one CPU-side native memory bus to NSLV slave buses,
// with a per-access ready timeout and sticky error reporting.
module mem_bus_decoder #(
    parameter int               NSLV     = 3,
    parameter logic [NSLV*32-1:0] SLV_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NSLV*32-1:0] SLV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFE_0000},
    parameter int               TIMEOUT  = 16,
    parameter logic [31:0]      ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m_valid,
    output logic               m_ready,
    input  logic [31:0]        m_addr,
    input  logic [31:0]        m_wdata,
    input  logic [3:0]         m_wstrb,
    output logic [31:0]        m_rdata,
    output logic [NSLV-1:0]    s_valid,
    input  logic [NSLV-1:0]    s_ready,
    output logic [31:0]        s_addr,
    output logic [31:0]        s_wdata,
    output logic [3:0]         s_wstrb,
    input  logic [NSLV*32-1:0] s_rdata,
    output logic               err_flag,
    output logic [31:0]        err_addr,
    output logic [7:0]         err_cnt,
    input  logic               err_clr
);

    localparam int          SW    = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic [SW-1:0] sel;
    logic [15:0]   tcnt;
    logic          hit;
    logic [SW-1:0] hit_idx;
    logic          err_event;
    logic [31:0]   err_event_addr;

    // Descending scan so the lowest matching index is the last one written.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((m_addr & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        err_event      = 1'b0;
        err_event_addr = s_addr;
        if (state == IDLE && m_valid && !hit) begin
            err_event      = 1'b1;
            err_event_addr = m_addr;
        end else if (state == ACCESS && !s_ready[sel] && tcnt == TLAST) begin
            err_event = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sel     <= '0;
            tcnt    <= '0;
            m_ready <= 1'b0;
            m_rdata <= '0;
            s_valid <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            m_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        if (hit) begin
                            sel     <= hit_idx;
                            s_addr  <= m_addr;
                            s_wdata <= m_wdata;
                            s_wstrb <= m_wstrb;
                            tcnt    <= '0;
                            s_valid <= NSLV'(1) << hit_idx;
                            state   <= ACCESS;
                        end else begin
                            m_rdata <= ERR_DATA;
                            m_ready <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    // Ready is checked before the limit so a same-cycle ready wins.
                    if (s_ready[sel]) begin
                        m_rdata <= s_rdata[sel*32 +: 32];
                        s_valid <= '0;
                        m_ready <= 1'b1;
                        state   <= DONE;
                    end else if (tcnt == TLAST) begin
                        m_rdata <= ERR_DATA;
                        s_valid <= '0;
                        m_ready <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A coincident error event beats err_clr and restarts the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (err_event) begin
            err_flag <= 1'b1;
            if (err_clr || !err_flag) err_addr <= err_event_addr;
            if (err_clr)                err_cnt <= 8'd1;
            else if (err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end
    end

endmodule
